// File: rtl/xor_gate_unit_if.sv
// xor_gate_unit_if: operand/result bundle shared by the XOR unit and whatever drives it
interface xor_gate_unit_if #(
  parameter int WIDTH = 1,
  parameter int CNT_W = 8
);
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [WIDTH-1:0] c;
  logic [WIDTH-1:0] c_q;
  logic             c_edge;
  logic [CNT_W-1:0] ones_cnt;
  modport master (output a, b, input c, c_q, c_edge, ones_cnt);
  modport slave (input a, b, output c, c_q, c_edge, ones_cnt);
endinterface

// File: rtl/xor_gate_unit.sv
// xor_gate_unit: bitwise XOR gate with registered copy, change strobe and saturating bit-0 ones counter
module xor_gate_unit #(
  parameter int WIDTH = 1,
  parameter int CNT_W = 8
) (
  input logic            clk,
  input logic            rst,
  xor_gate_unit_if.slave bus
);
  logic [WIDTH-1:0] x;
  logic [WIDTH-1:0] x_q;
  logic             edge_q;
  logic [CNT_W-1:0] cnt;
  assign x = bus.a ^ bus.b;
  assign bus.c = x;
  assign bus.c_q = x_q;
  assign bus.c_edge = edge_q;
  assign bus.ones_cnt = cnt;
  // the strobe compares against x_q before this edge overwrites it
  always_ff @(posedge clk) begin
    if (rst) begin
      x_q    <= '0;
      edge_q <= 1'b0;
      cnt    <= '0;
    end else begin
      x_q    <= x;
      edge_q <= (x != x_q);
      if (x[0] && cnt != '1) cnt <= cnt + 1'b1;
    end
  end
endmodule

// File: tb/tb_xor_gate_unit.sv
// tb_xor_gate_unit: directed checks of the XOR unit at WIDTH=1 and WIDTH=4
module tb_xor_gate_unit;
  logic clk = 1'b0;
  logic run = 1'b0;
  logic rst = 1'b0;
  int checks = 0;
  int errors = 0;
  xor_gate_unit_if #(.WIDTH(1), .CNT_W(8)) bus1 ();
  xor_gate_unit_if #(.WIDTH(4), .CNT_W(8)) bus4 ();
  xor_gate_unit #(.WIDTH(1), .CNT_W(8)) dut1 (.clk(clk), .rst(rst), .bus(bus1));
  xor_gate_unit #(.WIDTH(4), .CNT_W(8)) dut4 (.clk(clk), .rst(rst), .bus(bus4));
  always #5 if (run) clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask
  initial begin
    bus1.a = 1'b0; bus1.b = 1'b0;
    bus4.a = 4'b0; bus4.b = 4'b0;
    #10 chk("tt_00", 32'(bus1.c), 32'd0);
    bus1.a = 1'b1; bus1.b = 1'b0;
    #10 chk("tt_10", 32'(bus1.c), 32'd1);
    bus1.a = 1'b1; bus1.b = 1'b1;
    #10 chk("tt_11", 32'(bus1.c), 32'd0);
    bus1.a = 1'b0; bus1.b = 1'b1;
    #10 chk("tt_01", 32'(bus1.c), 32'd1);
    bus1.a = 1'b1; bus1.b = 1'b0;
    rst = 1'b1;
    #10 chk("c_before_clk", 32'(bus1.c), 32'd1);
    run = 1'b1;
    @(negedge clk);
    tick();
    chk("rst_c", 32'(bus1.c), 32'd1);
    tick();
    chk("rst_c_q", 32'(bus1.c_q), 32'd0);
    chk("rst_c_edge", 32'(bus1.c_edge), 32'd0);
    chk("rst_cnt", 32'(bus1.ones_cnt), 32'd0);
    chk("rst_c_hold", 32'(bus1.c), 32'd1);
    rst = 1'b0;
    tick();
    chk("lat_c_q", 32'(bus1.c_q), 32'd1);
    chk("lat_edge", 32'(bus1.c_edge), 32'd1);
    chk("lat_cnt", 32'(bus1.ones_cnt), 32'd1);
    tick();
    chk("hold_edge", 32'(bus1.c_edge), 32'd0);
    chk("hold_c_q", 32'(bus1.c_q), 32'd1);
    bus1.a = 1'b1; bus1.b = 1'b1;
    tick();
    chk("fall_c_q", 32'(bus1.c_q), 32'd0);
    chk("fall_edge", 32'(bus1.c_edge), 32'd1);
    chk("fall_cnt", 32'(bus1.ones_cnt), 32'd2);
    tick();
    chk("fall_edge_clr", 32'(bus1.c_edge), 32'd0);
    rst = 1'b1;
    bus1.a = 1'b0; bus1.b = 1'b1;
    tick();
    chk("cnt_rst", 32'(bus1.ones_cnt), 32'd0);
    rst = 1'b0;
    for (int k = 1; k <= 300; k++) begin
      tick();
      chk($sformatf("sat_%0d", k), 32'(bus1.ones_cnt), (k > 255) ? 32'd255 : 32'(k));
    end
    bus1.a = 1'b0; bus1.b = 1'b0;
    for (int k = 0; k < 5; k++) begin
      tick();
      chk("sat_hold", 32'(bus1.ones_cnt), 32'd255);
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    bus1.a = 1'b0; bus1.b = 1'b1;
    for (int k = 0; k < 37; k++) tick();
    chk("mid_pre", 32'(bus1.ones_cnt), 32'd37);
    rst = 1'b1;
    tick();
    chk("mid_cnt", 32'(bus1.ones_cnt), 32'd0);
    chk("mid_c_q", 32'(bus1.c_q), 32'd0);
    chk("mid_edge", 32'(bus1.c_edge), 32'd0);
    chk("mid_c", 32'(bus1.c), 32'd1);
    rst = 1'b0;
    tick();
    chk("resume_cnt", 32'(bus1.ones_cnt), 32'd1);
    chk("resume_c_q", 32'(bus1.c_q), 32'd1);
    chk("resume_edge", 32'(bus1.c_edge), 32'd1);
    tick();
    chk("resume_cnt2", 32'(bus1.ones_cnt), 32'd2);
    chk("w4_pre_c_q", 32'(bus4.c_q), 32'd0);
    bus4.a = 4'b1100; bus4.b = 4'b1010;
    #1 chk("w4_c", 32'(bus4.c), 32'h6);
    tick();
    chk("w4_c_q", 32'(bus4.c_q), 32'h6);
    chk("w4_edge", 32'(bus4.c_edge), 32'd1);
    chk("w4_cnt", 32'(bus4.ones_cnt), 32'd0);
    bus4.a = 4'b0001; bus4.b = 4'b0000;
    #1 chk("w4_c_b0", 32'(bus4.c), 32'h1);
    tick();
    chk("w4_cnt_b0", 32'(bus4.ones_cnt), 32'd1);
    chk("w4_c_q_b0", 32'(bus4.c_q), 32'h1);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
